// File: rtl/gf_power_sbox_seq_if.sv
// rtl/gf_power_sbox_seq_if.sv - request/response handshake bundle for the GF(2^N) power s-box
interface gf_power_sbox_seq_if #(
    parameter int N    = 6,
    parameter int EXPW = N
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    x;
    logic [EXPW-1:0] d;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    y;
    logic            busy;

    modport master (
        output in_valid, x, d, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, x, d, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/gf_power_sbox_seq.sv
// rtl/gf_power_sbox_seq.sv - sequential x^d power s-box over GF(2^N) with masked linear term
module gf_power_sbox_seq #(
    parameter int           N     = 6,
    parameter logic [N-1:0] POLY  = 6'b000011,
    parameter logic [N-1:0] TMASK = 6'b010100,
    parameter int           EXPW  = N
) (
    input  logic              clk,
    input  logic              rst_n,
    gf_power_sbox_seq_if.slave bus
);

    localparam int IW = (EXPW > 1) ? $clog2(EXPW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    acc;
    logic [N-1:0]    x_cap;
    logic [EXPW-1:0] d_cap;
    logic [IW-1:0]   idx;
    logic [N-1:0]    y_q;
    logic            in_ready;
    logic            accept;
    logic            t_bit;
    logic [N-1:0]    sq;
    logic [N-1:0]    step;

    // Polynomial-basis multiply: shift-and-add with on-the-fly reduction by the modulus.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        logic [N-1:0] s;
        r = '0;
        s = a;
        for (int i = 0; i < N; i++) begin
            if (b[i]) r = r ^ s;
            s = s[N-1] ? ((s << 1) ^ POLY) : (s << 1);
        end
        return r;
    endfunction

    assign accept = bus.in_valid && in_ready;
    assign t_bit  = ^(x_cap & TMASK);
    assign sq     = gf_mul(acc, acc);
    assign step   = d_cap[idx] ? gf_mul(sq, x_cap) : sq;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN);
    assign bus.y         = y_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and request acceptance; in_ready never looks at in_valid.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (idx == '0) state_nxt = DONE;
            end
            DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready) state_nxt = bus.in_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and MSB-first square-and-multiply, one exponent bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            x_cap <= '0;
            d_cap <= '0;
            idx   <= '0;
            y_q   <= '0;
        end else if (accept) begin
            x_cap <= bus.x;
            d_cap <= bus.d;
            acc   <= {{(N-1){1'b0}}, 1'b1};
            idx   <= IW'(EXPW - 1);
        end else if (state == RUN) begin
            acc <= step;
            idx <= idx - 1'b1;
            if (idx == '0) y_q <= step ^ {N{t_bit}};
        end
    end

endmodule

// File: doc/gf_power_sbox_seq.md
GF_POWER_SBOX_SEQ -- requirements
Module: gf_power_sbox_seq

Interface
REQ-001 SHALL have parameter N, default 6: field width; GF(2^N) in polynomial basis, legal range 3..8.
REQ-002 SHALL have parameter POLY, default 6'b000011: low N bits of the monic irreducible modulus (default x^6+x+1).
REQ-003 SHALL have parameter TMASK, default 6'b010100: selects the x bits whose parity forms the linear term t.
REQ-004 SHALL have parameter EXPW, default N: exponent width; legal range 1..2N.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  request presents x and d.
REQ-008 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-009 SHALL have port x  input  N  field element operand.
REQ-010 SHALL have port d  input  EXPW  runtime exponent.
REQ-011 SHALL have port out_valid  output  1  y holds a completed result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts y.
REQ-013 SHALL have port y  output  N  result x^d XOR {N{t}}.
REQ-014 SHALL have port busy  output  1  high in RUN state.

Function
REQ-015 SHALL compute y = x^d in GF(2^N) mod POLY, then XOR every bit with t = parity(x_cap & TMASK); x_cap is the captured x.
REQ-016 SHALL treat 0^0 as 1 and 0^d as 0 for d>0.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready); combinational, no dependence on in_valid.
REQ-019 SHALL accept a request on an edge where in_valid and in_ready are both high; at that edge it SHALL capture x and d, set acc=1, set bit index to EXPW-1, and enter RUN.
REQ-020 SHALL, in RUN, process one exponent bit per cycle MSB-first: acc <= acc^2, multiplied by x_cap when d_cap[idx]=1; idx decrements.
REQ-021 SHALL leave RUN for DONE on the edge that processes idx=0; out_valid SHALL rise exactly EXPW edges after the accepting edge.
REQ-022 SHALL hold y and out_valid stable in DONE while out_ready=0; changes on x, d and in_valid SHALL be ignored outside the accepting edge.
REQ-023 SHALL, in DONE with out_ready=1, retire the result on that edge; with a simultaneous accepted request it goes directly to RUN (back-to-back), else to IDLE.
REQ-024 SHALL drive out_valid high only in DONE and busy high only in RUN.
REQ-025 SHALL register y; y SHALL keep its last value outside DONE and SHALL NOT be read as valid there.
REQ-026 SHALL use single-cycle combinational square and multiply mod POLY; no multi-cycle paths.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, out_valid=0, busy=0, y=0, acc=0, captured x/d=0, idx=0; in_ready SHALL be 1 the first cycle after release.
REQ-028 SHALL abort any RUN or DONE transaction on reset assertion, with no result emitted after release.

Verification (N=6, POLY x^6+x+1, TMASK 010100, EXPW=6 unless noted)
REQ-029 SHALL cover x=0x02, d=6, accepted at edge k -> out_valid at edge k+6, y=0x03, busy high for 6 cycles.
REQ-030 SHALL cover x=0x04, d=0 -> y=0x3E (1 XOR all-ones, t=1); also x=0x00, d=5 -> y=0x00.
REQ-031 SHALL cover x=0x02, d=62 -> y=0x21 (inverse); x=0x02, d=63 -> y=0x01.
REQ-032 SHALL cover out_ready held 0 for 5 cycles in DONE -> y, out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept, busy next cycle.
REQ-033 SHALL cover rst_n pulsed low mid-RUN (idx=3) -> out_valid=0, busy=0 immediately; no out_valid before a new request.
REQ-034 SHALL cover exhaustive x in 0..63 with d=52 against a software GF(2^6) reference model of x^52 XOR {6{t}}.
